inst_rom_ldr: RTL and testbench

Instruction-memory responder on the core's fetch interface. It answers the core's `rom_ce_o`/`rom_addr_o` requests with `rom_data_i`, and holds a word-organised RAM that is filled at boot through a byte-serial load port. It sits outside the core next to the top level. While no valid image is present it returns NOPs and asserts a hold that keeps the core stalled.

---
 rtl/inst_rom_ldr_pkg.sv | 17 +
 rtl/inst_rom_ldr_byte_packer.sv | 41 ++++
 rtl/inst_rom_ldr.sv | 98 +++++++++
 tb/tb_inst_rom_ldr.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_ldr_pkg.sv
// Shared types and constants for the boot-loadable instruction ROM.
// Holds bus types, reset level and loader state encodings.
package inst_rom_ldr_pkg;

    typedef logic [31:0] inst_bus_t;
    typedef logic [31:0] inst_addr_bus_t;

    localparam inst_bus_t ZERO_WORD = 32'h0000_0000;
    localparam logic      RST_ENA   = 1'b0;

    typedef enum logic [1:0] {
        LDR_EMPTY = 2'd0,
        LDR_LOAD  = 2'd1,
        LDR_RUN   = 2'd2
    } ldr_state_e;

endpackage

// File: rtl/inst_rom_ldr_byte_packer.sv
// Packs accepted load bytes little-endian into 32-bit words.
// Emits a word strobe on the 4th lane or on the final byte.
module byte_packer
    import inst_rom_ldr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       acc,
    input  logic [7:0] data,
    input  logic       last,
    output logic       word_vld,
    output inst_bus_t  word
);

    logic [1:0] lane_q;
    inst_bus_t  asm_q;

    // Lanes at or above the current one are always zero in asm_q,
    // so a short final word comes out zero-padded for free.
    always_comb begin
        word     = asm_q | (inst_bus_t'(data) << {lane_q, 3'b000});
        word_vld = acc && ((lane_q == 2'd3) || last);
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENA || clr) begin
            lane_q <= 2'd0;
            asm_q  <= ZERO_WORD;
        end else if (acc) begin
            if (word_vld) begin
                lane_q <= 2'd0;
                asm_q  <= ZERO_WORD;
            end else begin
                lane_q <= lane_q + 2'd1;
                asm_q  <= word;
            end
        end
    end

endmodule

// File: rtl/inst_rom_ldr.sv
// Instruction memory responder with a byte-serial boot loader.
// Returns NOPs and holds the core until a complete image is loaded.
module inst_rom_ldr
    import inst_rom_ldr_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce_i,
    input  inst_addr_bus_t addr_i,
    output inst_bus_t      inst_o,
    output logic           hold_o,
    input  logic           ld_start_i,
    input  logic           ld_valid_i,
    input  logic [7:0]     ld_byte_i,
    input  logic           ld_last_i,
    output logic           ld_ready_o,
    output logic           ld_done_o,
    output logic           err_o
);

    localparam logic [ADDR_W:0] WADDR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    ldr_state_e      state_q, state_d;
    logic [ADDR_W:0] waddr_q;
    logic            err_q;
    logic            done_q;
    logic            acc;
    logic            word_vld;
    inst_bus_t       word;
    logic            full;
    logic            rd_ok;

    inst_bus_t mem [2**ADDR_W];

    assign full       = waddr_q[ADDR_W];
    assign ld_ready_o = (state_q == LDR_LOAD) && !ld_start_i;
    assign acc        = ld_valid_i && ld_ready_o;
    assign hold_o     = (state_q != LDR_RUN);
    assign ld_done_o  = done_q;
    assign err_o      = err_q;

    byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (ld_start_i),
        .acc      (acc),
        .data     (ld_byte_i),
        .last     (ld_last_i),
        .word_vld (word_vld),
        .word     (word)
    );

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            ld_start_i:              state_d = LDR_LOAD;
            (acc && ld_last_i):      state_d = LDR_RUN;
            default:                 state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            state_q <= LDR_EMPTY;
            waddr_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= acc && ld_last_i;
            if (ld_start_i) begin
                waddr_q <= '0;
                err_q   <= 1'b0;
            end else begin
                // Any byte arriving once the array is full is lost data.
                if (acc && full)
                    err_q <= 1'b1;
                if (word_vld && !full)
                    waddr_q <= waddr_q + WADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (word_vld && !full)
            mem[waddr_q[ADDR_W-1:0]] <= word;
    end

    always_comb begin
        rd_ok = (state_q == LDR_RUN) && ce_i
             && (addr_i[1:0] == 2'b00)
             && ((addr_i >> (ADDR_W + 2)) == '0);
        inst_o = rd_ok ? mem[addr_i[ADDR_W+1:2]] : ZERO_WORD;
    end

endmodule

// File: tb/tb_inst_rom_ldr.sv
// Scoreboard bench for inst_rom_ldr with a 4-word array.
// Directed loads, fetch boundaries, overflow and collisions.
module tb_inst_rom_ldr;

    localparam int ADDR_W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic        hold_o;
    logic        ld_start_i;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_last_i;
    logic        ld_ready_o;
    logic        ld_done_o;
    logic        err_o;

    inst_rom_ldr #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .inst_o     (inst_o),
        .hold_o     (hold_o),
        .ld_start_i (ld_start_i),
        .ld_valid_i (ld_valid_i),
        .ld_byte_i  (ld_byte_i),
        .ld_last_i  (ld_last_i),
        .ld_ready_o (ld_ready_o),
        .ld_done_o  (ld_done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef enum int {K_INST, K_HOLD, K_READY, K_DONE, K_ERR} kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    logic dq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] actual(input kind_e k);
        case (k)
            K_INST:  return inst_o;
            K_HOLD:  return {31'd0, hold_o};
            K_READY: return {31'd0, ld_ready_o};
            K_DONE:  return {31'd0, ld_done_o};
            default: return {31'd0, err_o};
        endcase
    endfunction

    // Monitor: pops expectations tagged for this cycle and the done events.
    always @(negedge clk) begin
        chk_t c;
        logic e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            c = q.pop_front();
            checks++;
            if (c.cyc != cyc || actual(c.kind) !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", c.name,
                         actual(c.kind), c.exp);
            end
        end
        if (ld_done_o) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got 1 want 0");
            end else begin
                e = dq.pop_front();
                if (hold_o !== 1'b0 || err_o !== e) begin
                    errors++;
                    $display("FAIL done_state: hold %b err %b want 0 %b",
                             hold_o, err_o, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input kind_e k, input logic [31:0] v,
                              input string n);
        q.push_back('{cyc, k, v, n});
    endtask

    task automatic start();
        ld_start_i = 1'b1;
        tick();
        ld_start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last,
                        input logic err_at_done);
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        ld_last_i  = last;
        if (last) dq.push_back(err_at_done);
        tick();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    task automatic fetch(input logic ce, input logic [31:0] a,
                         input logic [31:0] v, input string n);
        ce_i   = ce;
        addr_i = a;
        expect_now(K_INST, v, n);
        tick();
    endtask

    initial begin
        rst = 1'b0; ce_i = 1'b1; addr_i = '0;
        ld_start_i = 1'b0; ld_valid_i = 1'b0;
        ld_byte_i = '0; ld_last_i = 1'b0;
        tick(); tick();

        // 1: reset state
        expect_now(K_INST, 0, "rst_inst");
        expect_now(K_HOLD, 1, "rst_hold");
        expect_now(K_READY, 0, "rst_ready");
        expect_now(K_ERR, 0, "rst_err");
        expect_now(K_DONE, 0, "rst_done");
        rst = 1'b1;
        tick();

        // 2: full word
        start();
        expect_now(K_READY, 1, "load_ready");
        expect_now(K_HOLD, 1, "load_hold");
        send(8'h13, 0, 0); send(8'h05, 0, 0);
        send(8'h10, 0, 0); send(8'h00, 1, 0);
        fetch(1, 32'h0, 32'h0010_0513, "full_word");
        expect_now(K_DONE, 0, "done_one_cycle");
        tick();

        // 3: partial word
        start();
        for (int i = 0; i < 6; i++)
            send(8'h11 + 8'(i), i == 5, 0);
        fetch(1, 32'h4, 32'h0000_1615, "partial_word");
        fetch(1, 32'h0, 32'h1413_1211, "word0_reload");

        // 4: boundary fetches
        fetch(1, 32'h2, 0, "misaligned");
        fetch(1, 32'h10, 0, "out_of_range");
        fetch(0, 32'h0, 0, "ce_low");

        // mid-RUN start raises hold next cycle
        ce_i = 1'b1; addr_i = '0;
        start();
        expect_now(K_HOLD, 1, "midrun_hold");
        expect_now(K_INST, 0, "midrun_nop");

        // 5: overflow
        for (int i = 1; i <= 20; i++) begin
            send(8'(i), i == 20, 1);
            if (i == 16) expect_now(K_ERR, 0, "err_before_ovf");
            if (i == 17) expect_now(K_ERR, 1, "err_after_17");
        end
        expect_now(K_HOLD, 0, "ovf_run");
        fetch(1, 32'hC, 32'h100F_0E0D, "ovf_word3");
        fetch(1, 32'h0, 32'h0403_0201, "ovf_word0");
        start();
        expect_now(K_ERR, 0, "err_cleared");

        // 6a: start collides with a valid byte
        send(8'hAA, 0, 0);
        ld_start_i = 1'b1; ld_valid_i = 1'b1; ld_byte_i = 8'hBB;
        expect_now(K_READY, 0, "collide_ready");
        tick();
        ld_start_i = 1'b0; ld_valid_i = 1'b0;
        send(8'h21, 0, 0); send(8'h22, 0, 0);
        send(8'h23, 0, 0); send(8'h24, 1, 0);
        fetch(1, 32'h0, 32'h2423_2221, "collide_lane0");

        // 6b: reset mid-load, last byte offered in the reset cycle
        start();
        send(8'h55, 0, 0);
        rst = 1'b0;
        ld_valid_i = 1'b1; ld_byte_i = 8'h66; ld_last_i = 1'b1;
        tick();
        ld_valid_i = 1'b0; ld_last_i = 1'b0;
        rst = 1'b1;
        expect_now(K_HOLD, 1, "rst_mid_hold");
        expect_now(K_DONE, 0, "rst_mid_nodone");
        expect_now(K_READY, 0, "rst_mid_ready");
        tick();
        expect_now(K_HOLD, 1, "empty_hold");
        expect_now(K_INST, 0, "empty_nop");
        tick(); tick();

        checks++;
        if (dq.size() != 0 || q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d done %0d chk want 0 0",
                     dq.size(), q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
